// File: rtl/tlb_if.sv
// Bus bundle for the tlb: search, write, read, INVTLB and statistics ports.
// master = pipeline / translation unit side, slave = tlb.
interface tlb_if #(
   parameter int TLBNUM = 16
);
   localparam int IW = $clog2(TLBNUM);

   logic [18:0]   s_vppn;
   logic          s_va_bit12;
   logic [9:0]    s_asid;
   logic          s_req;
   logic          s_found;
   logic [IW-1:0] s_index;
   logic [19:0]   s_ppn;
   logic [5:0]    s_ps;
   logic [1:0]    s_plv;
   logic [1:0]    s_mat;
   logic          s_d;
   logic          s_v;

   logic          we;
   logic [IW-1:0] w_index;
   logic          w_e;
   logic [18:0]   w_vppn;
   logic [5:0]    w_ps;
   logic [9:0]    w_asid;
   logic          w_g;
   logic [19:0]   w_ppn0;
   logic [1:0]    w_plv0;
   logic [1:0]    w_mat0;
   logic          w_d0;
   logic          w_v0;
   logic [19:0]   w_ppn1;
   logic [1:0]    w_plv1;
   logic [1:0]    w_mat1;
   logic          w_d1;
   logic          w_v1;

   logic [IW-1:0] r_index;
   logic          r_e;
   logic [18:0]   r_vppn;
   logic [5:0]    r_ps;
   logic [9:0]    r_asid;
   logic          r_g;
   logic [19:0]   r_ppn0;
   logic [1:0]    r_plv0;
   logic [1:0]    r_mat0;
   logic          r_d0;
   logic          r_v0;
   logic [19:0]   r_ppn1;
   logic [1:0]    r_plv1;
   logic [1:0]    r_mat1;
   logic          r_d1;
   logic          r_v1;

   logic          inv_valid;
   logic          inv_ready;
   logic [4:0]    inv_op;
   logic [9:0]    inv_asid;
   logic [18:0]   inv_va;
   logic          inv_done;

   logic [31:0]   hit_cnt;
   logic [31:0]   miss_cnt;

   modport master (
      output s_vppn, s_va_bit12, s_asid, s_req,
      input  s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v,
      output we, w_index, w_e, w_vppn, w_ps, w_asid, w_g,
      output w_ppn0, w_plv0, w_mat0, w_d0, w_v0,
      output w_ppn1, w_plv1, w_mat1, w_d1, w_v1,
      output r_index,
      input  r_e, r_vppn, r_ps, r_asid, r_g,
      input  r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
      input  r_ppn1, r_plv1, r_mat1, r_d1, r_v1,
      output inv_valid, inv_op, inv_asid, inv_va,
      input  inv_ready, inv_done,
      input  hit_cnt, miss_cnt
   );

   modport slave (
      input  s_vppn, s_va_bit12, s_asid, s_req,
      output s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v,
      input  we, w_index, w_e, w_vppn, w_ps, w_asid, w_g,
      input  w_ppn0, w_plv0, w_mat0, w_d0, w_v0,
      input  w_ppn1, w_plv1, w_mat1, w_d1, w_v1,
      input  r_index,
      output r_e, r_vppn, r_ps, r_asid, r_g,
      output r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
      output r_ppn1, r_plv1, r_mat1, r_d1, r_v1,
      input  inv_valid, inv_op, inv_asid, inv_va,
      output inv_ready, inv_done,
      output hit_cnt, miss_cnt
   );
endinterface

// File: rtl/tlb.sv
// Fully associative LoongArch-style TLB with combinational search/read and a
// multi-cycle INVTLB sweep engine. Define TLB_PERF_CNT_EN for hit/miss counters.
module tlb #(
   parameter int TLBNUM = 16
) (
   input logic   clk,
   input logic   resetn,
   tlb_if.slave  bus
);
   localparam int IW = $clog2(TLBNUM);
   localparam logic [5:0] PS_2M = 6'd21;

   typedef struct packed {
      logic        e;
      logic [18:0] vppn;
      logic [5:0]  ps;
      logic [9:0]  asid;
      logic        g;
      logic [19:0] ppn0;
      logic [1:0]  plv0;
      logic [1:0]  mat0;
      logic        d0;
      logic        v0;
      logic [19:0] ppn1;
      logic [1:0]  plv1;
      logic [1:0]  mat1;
      logic        d1;
      logic        v1;
   } entry_t;

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   entry_t        entry_q [TLBNUM];
   entry_t        entry_d [TLBNUM];
   state_t        state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic [4:0]    op_q, op_d;
   logic [9:0]    asid_q, asid_d;
   logic [18:0]   va_q, va_d;
   logic          inv_ready_q, inv_ready_d;
   logic          inv_done_q, inv_done_d;

   // A 2M page only tags the upper ten VPPN bits.
   function automatic logic vppn_hit(entry_t ent, logic [18:0] va);
      return (ent.ps == PS_2M) ? (ent.vppn[18:9] == va[18:9]) : (ent.vppn == va);
   endfunction

   function automatic logic inv_hit(entry_t ent, logic [4:0] op, logic [9:0] asid,
                                    logic [18:0] va);
      logic asid_eq;
      asid_eq = (ent.asid == asid);
      case (op)
         5'd0, 5'd1: return 1'b1;
         5'd2:       return ent.g;
         5'd3:       return !ent.g;
         5'd4:       return !ent.g && asid_eq;
         5'd5:       return !ent.g && asid_eq && vppn_hit(ent, va);
         5'd6:       return (ent.g || asid_eq) && vppn_hit(ent, va);
         default:    return 1'b0;
      endcase
   endfunction

   entry_t        sel;
   logic          found;
   logic [IW-1:0] hit_idx;
   logic          odd;

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      found   = 1'b0;
      hit_idx = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (entry_q[i].e && (entry_q[i].g || entry_q[i].asid == bus.s_asid) &&
             vppn_hit(entry_q[i], bus.s_vppn)) begin
            found   = 1'b1;
            hit_idx = IW'(i);
         end
      end
      sel = entry_q[hit_idx];
      odd = (sel.ps == PS_2M) ? bus.s_vppn[8] : bus.s_va_bit12;

      bus.s_found = found;
      bus.s_index = hit_idx;
      bus.s_ps    = found ? sel.ps : '0;
      bus.s_ppn   = !found ? '0 : (odd ? sel.ppn1 : sel.ppn0);
      bus.s_plv   = !found ? '0 : (odd ? sel.plv1 : sel.plv0);
      bus.s_mat   = !found ? '0 : (odd ? sel.mat1 : sel.mat0);
      bus.s_d     = found && (odd ? sel.d1 : sel.d0);
      bus.s_v     = found && (odd ? sel.v1 : sel.v0);
   end

   entry_t rd;

   always_comb begin
      rd         = entry_q[bus.r_index];
      bus.r_e    = rd.e;
      bus.r_vppn = rd.vppn;
      bus.r_ps   = rd.ps;
      bus.r_asid = rd.asid;
      bus.r_g    = rd.g;
      bus.r_ppn0 = rd.ppn0;
      bus.r_plv0 = rd.plv0;
      bus.r_mat0 = rd.mat0;
      bus.r_d0   = rd.d0;
      bus.r_v0   = rd.v0;
      bus.r_ppn1 = rd.ppn1;
      bus.r_plv1 = rd.plv1;
      bus.r_mat1 = rd.mat1;
      bus.r_d1   = rd.d1;
      bus.r_v1   = rd.v1;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      asid_d     = asid_q;
      va_d       = va_q;
      inv_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.inv_valid) begin
               op_d    = bus.inv_op;
               asid_d  = bus.inv_asid;
               va_d    = bus.inv_va;
               cnt_d   = '0;
               state_d = SWEEP;
            end
         end
         SWEEP: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IW'(TLBNUM - 1)) begin
               state_d    = DONE;
               inv_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      inv_ready_d = (state_d == IDLE);

      entry_d = entry_q;
      if (state_q == SWEEP && inv_hit(entry_q[cnt_q], op_q, asid_q, va_q))
         entry_d[cnt_q].e = 1'b0;
      // Applied after the sweep clear so a same-entry write wins.
      if (bus.we)
         entry_d[bus.w_index] = '{e: bus.w_e, vppn: bus.w_vppn, ps: bus.w_ps,
                                  asid: bus.w_asid, g: bus.w_g,
                                  ppn0: bus.w_ppn0, plv0: bus.w_plv0, mat0: bus.w_mat0,
                                  d0: bus.w_d0, v0: bus.w_v0,
                                  ppn1: bus.w_ppn1, plv1: bus.w_plv1, mat1: bus.w_mat1,
                                  d1: bus.w_d1, v1: bus.w_v1};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         // NOTE: the entry array is reset on purpose; a stale e=1 would produce false hits.
         for (int i = 0; i < TLBNUM; i++) entry_q[i] <= '0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         asid_q      <= '0;
         va_q        <= '0;
         inv_ready_q <= 1'b1;
         inv_done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep all state updates in this edge order-independent.
         for (int i = 0; i < TLBNUM; i++) entry_q[i] <= entry_d[i];
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         asid_q      <= asid_d;
         va_q        <= va_d;
         inv_ready_q <= inv_ready_d;
         inv_done_q  <= inv_done_d;
      end
   end

   assign bus.inv_ready = inv_ready_q;
   assign bus.inv_done  = inv_done_q;

`ifdef TLB_PERF_CNT_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (bus.s_req) begin
         if (found) hit_cnt_d  = hit_cnt_q + 32'd1;
         else       miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign bus.hit_cnt  = hit_cnt_q;
   assign bus.miss_cnt = miss_cnt_q;
`else
   assign bus.hit_cnt  = '0;
   assign bus.miss_cnt = '0;
`endif
endmodule

// File: tb/tb_tlb.sv
// Directed scoreboard bench for tlb: search, priority, read, INVTLB timing and
// ops, write-vs-sweep collision, statistics and reset mid-sweep.
module tb_tlb;
   localparam int TLBNUM = 16;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   tlb_if #(.TLBNUM(TLBNUM)) bus ();
   tlb #(.TLBNUM(TLBNUM)) u_dut (.clk(clk), .resetn(resetn), .bus(bus));

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       tag;
      logic        found;
      logic [3:0]  idx;
      logic [19:0] ppn;
      logic [5:0]  ps;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive a search key, push its expectation, then pop and compare the response.
   task automatic search(input string tag, input logic [18:0] vppn, input logic b12,
                         input logic [9:0] asid, input logic found, input logic [3:0] idx,
                         input logic [19:0] ppn, input logic [5:0] ps);
      exp_t e;
      bus.s_vppn     = vppn;
      bus.s_va_bit12 = b12;
      bus.s_asid     = asid;
      sb.push_back('{tag, found, idx, ppn, ps});
      #1;
      e = sb.pop_front();
      check({e.tag, "_found"}, 32'(bus.s_found), 32'(e.found));
      check({e.tag, "_index"}, 32'(bus.s_index), 32'(e.idx));
      check({e.tag, "_ppn"},   32'(bus.s_ppn),   32'(e.ppn));
      check({e.tag, "_ps"},    32'(bus.s_ps),    32'(e.ps));
   endtask

   task automatic set_wr(input logic [3:0] idx, input logic e, input logic [18:0] vppn,
                         input logic [5:0] ps, input logic [9:0] asid, input logic g,
                         input logic [19:0] ppn0, input logic [19:0] ppn1);
      bus.w_index = idx;  bus.w_e = e;  bus.w_vppn = vppn;  bus.w_ps = ps;
      bus.w_asid = asid;  bus.w_g = g;
      bus.w_ppn0 = ppn0;  bus.w_plv0 = 2'd0;  bus.w_mat0 = 2'd1;  bus.w_d0 = 1'b1;  bus.w_v0 = 1'b1;
      bus.w_ppn1 = ppn1;  bus.w_plv1 = 2'd3;  bus.w_mat1 = 2'd2;  bus.w_d1 = 1'b0;  bus.w_v1 = 1'b1;
   endtask

   task automatic wr(input logic [3:0] idx, input logic e, input logic [18:0] vppn,
                     input logic [5:0] ps, input logic [9:0] asid, input logic g,
                     input logic [19:0] ppn0, input logic [19:0] ppn1);
      set_wr(idx, e, vppn, ps, asid, g, ppn0, ppn1);
      bus.we = 1'b1;
      @(posedge clk); #1;
      bus.we = 1'b0;
   endtask

   task automatic get_mask(output logic [15:0] m);
      m = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         bus.r_index = 4'(i);
         #1;
         m[i] = bus.r_e;
      end
   endtask

   // Issue one INVTLB; optionally raise we (fields preloaded) at sample point wr_at.
   task automatic do_inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] va,
                         input int wr_at, output int low_cnt, output int done_at,
                         output int done_cnt);
      check("inv_ready_before", 32'(bus.inv_ready), 32'd1);
      bus.inv_op = op;  bus.inv_asid = asid;  bus.inv_va = va;
      bus.inv_valid = 1'b1;
      @(posedge clk); #1;
      bus.inv_valid = 1'b0;
      bus.inv_op = '0;  bus.inv_asid = '0;  bus.inv_va = '0;
      low_cnt = 0;  done_at = 0;  done_cnt = 0;
      for (int n = 1; n <= 40; n++) begin
         if (!bus.inv_ready) low_cnt++;
         if (bus.inv_done) begin
            done_cnt++;
            done_at = n;
         end
         if (bus.inv_ready) break;
         if (n == wr_at) bus.we = 1'b1;
         @(posedge clk); #1;
         bus.we = 1'b0;
      end
   endtask

   initial begin
      logic [15:0] mask;
      int low, dat, dcnt;

      bus.s_vppn = '0;  bus.s_va_bit12 = 1'b0;  bus.s_asid = '0;  bus.s_req = 1'b0;
      bus.we = 1'b0;  set_wr(4'd0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
      bus.r_index = '0;
      bus.inv_valid = 1'b0;  bus.inv_op = '0;  bus.inv_asid = '0;  bus.inv_va = '0;

      #12 resetn = 1'b1;
      @(posedge clk); #1;

      // Reset state
      check("rst_found", 32'(bus.s_found), 32'd0);
      check("rst_inv_ready", 32'(bus.inv_ready), 32'd1);
      check("rst_inv_done", 32'(bus.inv_done), 32'd0);
      check("rst_hit_cnt", bus.hit_cnt, 32'd0);
      check("rst_miss_cnt", bus.miss_cnt, 32'd0);
      get_mask(mask);
      check("rst_mask", 32'(mask), 32'h0);

      // 4K page, ASID-private
      wr(4'd3, 1'b1, 19'h00010, 6'd12, 10'd5, 1'b0, 20'h11111, 20'h22222);
      search("s4k_odd",  19'h00010, 1'b1, 10'd5, 1'b1, 4'd3, 20'h22222, 6'd12);
      search("s4k_even", 19'h00010, 1'b0, 10'd5, 1'b1, 4'd3, 20'h11111, 6'd12);
      search("s4k_asid", 19'h00010, 1'b1, 10'd6, 1'b0, 4'd0, 20'h0, 6'd0);

      // 2M global page, odd select via s_vppn[8]
      wr(4'd7, 1'b1, 19'h40000, 6'd21, 10'd0, 1'b1, 20'h33333, 20'h44444);
      search("s2m_even", 19'h400FF, 1'b1, 10'h3A5, 1'b1, 4'd7, 20'h33333, 6'd21);
      search("s2m_odd",  19'h40100, 1'b0, 10'h011, 1'b1, 4'd7, 20'h44444, 6'd21);
      check("s2m_plv", 32'(bus.s_plv), 32'd3);

      // Duplicate tags: lowest index wins
      wr(4'd9, 1'b1, 19'h00123, 6'd12, 10'd1, 1'b1, 20'h0AAAA, 20'h0BBBB);
      wr(4'd2, 1'b1, 19'h00123, 6'd12, 10'd1, 1'b1, 20'h0CCCC, 20'h0DDDD);
      search("s_prio", 19'h00123, 1'b0, 10'd2, 1'b1, 4'd2, 20'h0CCCC, 6'd12);
      bus.r_index = 4'd9;  #1;
      check("rd_vppn9", 32'(bus.r_vppn), 32'h00123);
      check("rd_ppn1_9", 32'(bus.r_ppn1), 32'h0BBBB);

      // Fill, alternating g (odd entries global)
      for (int i = 0; i < TLBNUM; i++)
         wr(4'(i), 1'b1, 19'(32'h100 + i), 6'd12, 10'(i), i[0], 20'(i), 20'(i + 16));

      do_inv(5'd2, '0, '0, 0, low, dat, dcnt);
      check("op2_ready_low", 32'(low), 32'd17);
      check("op2_done_at", 32'(dat), 32'd17);
      check("op2_done_cnt", 32'(dcnt), 32'd1);
      get_mask(mask);
      check("op2_mask", 32'(mask), 32'h5555);

      do_inv(5'd4, 10'd4, '0, 0, low, dat, dcnt);
      get_mask(mask);
      check("op4_mask", 32'(mask), 32'h5545);

      do_inv(5'd5, 10'd6, 19'h00106, 0, low, dat, dcnt);
      get_mask(mask);
      check("op5_mask", 32'(mask), 32'h5505);

      do_inv(5'd9, '0, '0, 0, low, dat, dcnt);
      check("op9_ready_low", 32'(low), 32'd17);
      check("op9_done_cnt", 32'(dcnt), 32'd1);
      get_mask(mask);
      check("op9_mask", 32'(mask), 32'h5505);

      // Write to entry 5 lands on the edge that sweeps entry 5
      set_wr(4'd5, 1'b1, 19'h07777, 6'd12, 10'd2, 1'b0, 20'h12345, 20'h54321);
      do_inv(5'd0, '0, '0, 6, low, dat, dcnt);
      check("op0_done_cnt", 32'(dcnt), 32'd1);
      get_mask(mask);
      check("op0_wr_mask", 32'(mask), 32'h0020);
      bus.r_index = 4'd5;  #1;
      check("op0_wr_vppn", 32'(bus.r_vppn), 32'h07777);

      // Statistics: 3 hits then 1 miss
      wr(4'd3, 1'b1, 19'h00010, 6'd12, 10'd5, 1'b0, 20'h11111, 20'h22222);
      bus.s_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k < 3) search("perf_hit", 19'h00010, 1'b0, 10'd5, 1'b1, 4'd3, 20'h11111, 6'd12);
         else       search("perf_miss", 19'h00011, 1'b0, 10'd5, 1'b0, 4'd0, 20'h0, 6'd0);
         @(posedge clk); #1;
      end
      bus.s_req = 1'b0;
`ifdef TLB_PERF_CNT_EN
      check("perf_hit_cnt", bus.hit_cnt, 32'd3);
      check("perf_miss_cnt", bus.miss_cnt, 32'd1);
`else
      check("perf_hit_cnt", bus.hit_cnt, 32'd0);
      check("perf_miss_cnt", bus.miss_cnt, 32'd0);
`endif

      // Reset in the middle of a sweep
      bus.inv_op = 5'd0;
      bus.inv_valid = 1'b1;
      @(posedge clk); #1;
      bus.inv_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      check("mrst_inv_ready", 32'(bus.inv_ready), 32'd1);
      check("mrst_inv_done", 32'(bus.inv_done), 32'd0);
      check("mrst_hit_cnt", bus.hit_cnt, 32'd0);
      check("mrst_miss_cnt", bus.miss_cnt, 32'd0);
      search("mrst_search", 19'h00010, 1'b0, 10'd5, 1'b0, 4'd0, 20'h0, 6'd0);
      @(negedge clk);
      resetn = 1'b1;
      dcnt = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (bus.inv_done) dcnt++;
      end
      check("mrst_no_done", 32'(dcnt), 32'd0);
      check("mrst_ready", 32'(bus.inv_ready), 32'd1);
      get_mask(mask);
      check("mrst_mask", 32'(mask), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
